// File: rtl/alu_pkg.sv
// Shared definitions for the 6-bit signed ALU: operand width and load-FSM states.
// The display stage decodes state_led using load_state_t.
package alu_pkg;

  localparam int WIDTH = 6;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_READY  = 2'b10
  } load_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter, and a one-cycle
// press pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CNT = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous raw button.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level once it has held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level       <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level       <= sync_q2;
        cnt         <= '0;
        press_pulse <= sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU front end: captures operands A and B from the switches on debounced ENTER
// presses and presents them with a valid flag once both are held.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH        = alu_pkg::WIDTH,
  parameter int DEBOUNCE_CNT = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             operands_valid,
  output logic             ready_pulse,
  output logic [1:0]       state_led
);

  logic [WIDTH-1:0] sw_q1;
  logic [WIDTH-1:0] sw_sync;
  logic             enter_p;
  logic             clear_p;
  load_state_t      state;

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_enter_db (
    .clk         (clk),
    .reset       (reset),
    .raw         (btn_enter),
    .level       (),
    .press_pulse (enter_p)
  );

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_clear_db (
    .clk         (clk),
    .reset       (reset),
    .raw         (btn_clear),
    .level       (),
    .press_pulse (clear_p)
  );

  // Two-flop synchroniser for the switch bank; the operands are taken from sw_sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_q1   <= sw;
      sw_sync <= sw_q1;
    end
  end

  // Load sequencer and operand registers; CLEAR takes priority over a same-cycle ENTER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_LOAD_A;
      a_out          <= '0;
      b_out          <= '0;
      operands_valid <= 1'b0;
      ready_pulse    <= 1'b0;
    end else begin
      ready_pulse <= 1'b0;
      if (clear_p) begin
        state          <= S_LOAD_A;
        a_out          <= '0;
        b_out          <= '0;
        operands_valid <= 1'b0;
      end else if (enter_p) begin
        case (state)
          S_LOAD_A: begin
            a_out <= sw_sync;
            state <= S_LOAD_B;
          end
          S_LOAD_B: begin
            b_out          <= sw_sync;
            state          <= S_READY;
            operands_valid <= 1'b1;
            ready_pulse    <= 1'b1;
          end
          default: begin
            state          <= S_LOAD_A;
            operands_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;

  localparam int W   = 6;
  localparam int DBC = 4;
  localparam int LAT = DBC + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         operands_valid;
  logic         ready_pulse;
  logic [1:0]   state_led;

  int tests_run = 0;
  int tests_failed = 0;
  int rp_cnt = 0;
  int ep_cnt = 0;

  alu_operand_loader #(.WIDTH(W), .DEBOUNCE_CNT(DBC)) dut (
    .clk            (clk),
    .reset          (reset),
    .sw             (sw),
    .btn_enter      (btn_enter),
    .btn_clear      (btn_clear),
    .a_out          (a_out),
    .b_out          (b_out),
    .operands_valid (operands_valid),
    .ready_pulse    (ready_pulse),
    .state_led      (state_led)
  );

  always #5 clk = ~clk;

  // Count ready pulses and accepted ENTER presses, sampled away from the active edge.
  always @(negedge clk) begin
    if (ready_pulse === 1'b1) rp_cnt = rp_cnt + 1;
    if (dut.u_enter_db.press_pulse === 1'b1) ep_cnt = ep_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold ENTER (optionally with CLEAR) and report cycles until state_led changes.
  task automatic press(input logic with_clear, output int lat);
    logic [1:0] prev;
    prev = state_led;
    lat = -1;
    btn_enter = 1'b1;
    btn_clear = with_clear;
    for (int k = 1; k <= 3 * DBC + 10; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && state_led !== prev) lat = k;
    end
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(3 * DBC + 6);
  endtask

  task automatic check_lat(input string name, input int lat);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL %s: latency %0d, expected %0d", name, lat, LAT);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sw = '0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(3);
    tests_run++;
    if ({a_out, b_out, state_led, operands_valid, ready_pulse} !== {6'd0, 6'd0, 2'b00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: a=%b b=%b st=%b v=%b rp=%b, expected all zero",
               a_out, b_out, state_led, operands_valid, ready_pulse);
    end
  endtask

  task automatic test_load_pair;
    int lat;
    sw = 6'b111101;
    press(1'b0, lat);
    check_lat("load_a_latency", lat);
    tests_run++;
    if (a_out !== 6'b111101 || state_led !== 2'b01 || operands_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_a: a=%b st=%b v=%b, expected a=111101 st=01 v=0",
               a_out, state_led, operands_valid);
    end
    rp_cnt = 0;
    sw = 6'b000101;
    press(1'b0, lat);
    check_lat("load_b_latency", lat);
    tests_run++;
    if (a_out !== 6'b111101 || b_out !== 6'b000101) begin
      tests_failed++;
      $display("FAIL load_b_ops: a=%b b=%b, expected a=111101 b=000101", a_out, b_out);
    end
    tests_run++;
    if (operands_valid !== 1'b1 || state_led !== 2'b10) begin
      tests_failed++;
      $display("FAIL load_b_ready: v=%b st=%b, expected v=1 st=10", operands_valid, state_led);
    end
    tests_run++;
    if (rp_cnt !== 1) begin
      tests_failed++;
      $display("FAIL ready_pulse_count: %0d cycles high, expected 1", rp_cnt);
    end
  endtask

  task automatic test_ready_exit;
    int lat;
    rp_cnt = 0;
    sw = 6'b011011;
    press(1'b0, lat);
    tests_run++;
    if (operands_valid !== 1'b0 || state_led !== 2'b00) begin
      tests_failed++;
      $display("FAIL ready_exit_state: v=%b st=%b, expected v=0 st=00", operands_valid, state_led);
    end
    tests_run++;
    if (a_out !== 6'b111101 || b_out !== 6'b000101 || rp_cnt !== 0) begin
      tests_failed++;
      $display("FAIL ready_exit_hold: a=%b b=%b rp=%0d, expected a=111101 b=000101 rp=0",
               a_out, b_out, rp_cnt);
    end
  endtask

  task automatic test_bounce;
    ep_cnt = 0;
    sw = 6'b001010;
    btn_enter = 1'b1; tick(1);
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(1);
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(20);
    btn_enter = 1'b0; tick(3 * DBC + 6);
    tests_run++;
    if (ep_cnt !== 1) begin
      tests_failed++;
      $display("FAIL bounce_pulses: %0d press pulses, expected 1", ep_cnt);
    end
    tests_run++;
    if (state_led !== 2'b01 || a_out !== 6'b001010) begin
      tests_failed++;
      $display("FAIL bounce_advance: st=%b a=%b, expected st=01 a=001010", state_led, a_out);
    end
  endtask

  task automatic test_clear_wins;
    int lat;
    rp_cnt = 0;
    sw = 6'b010101;
    press(1'b1, lat);
    tests_run++;
    if (state_led !== 2'b00 || a_out !== 6'd0 || b_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL clear_wins: st=%b a=%b b=%b, expected st=00 a=0 b=0", state_led, a_out, b_out);
    end
    tests_run++;
    if (rp_cnt !== 0 || operands_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_no_ready: rp=%0d v=%b, expected rp=0 v=0", rp_cnt, operands_valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    sw = 6'b000011;
    press(1'b0, lat);
    tests_run++;
    if (state_led !== 2'b01 || a_out !== 6'b000011) begin
      tests_failed++;
      $display("FAIL mid_setup: st=%b a=%b, expected st=01 a=000011", state_led, a_out);
    end
    sw = 6'b011000;
    btn_enter = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    tests_run++;
    if (a_out !== 6'd0 || state_led !== 2'b00 || operands_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: a=%b st=%b v=%b, expected a=0 st=00 v=0",
               a_out, state_led, operands_valid);
    end
    btn_enter = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(3 * DBC + 6);
    tests_run++;
    if (state_led !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_discard: st=%b, expected 00", state_led);
    end
    press(1'b0, lat);
    check_lat("post_reset_latency", lat);
    tests_run++;
    if (state_led !== 2'b01 || a_out !== 6'b011000 || b_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL post_reset_load: st=%b a=%b b=%b, expected st=01 a=011000 b=0",
               state_led, a_out, b_out);
    end
  endtask

  initial begin
    test_reset();
    test_load_pair();
    test_ready_exit();
    test_bounce();
    test_clear_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
